// File: rtl/mdu_pkg.sv
// Shared MDU definitions: request opcodes, divider FSM state type and the
// fixed divider busy latency used by the multiplier and the benches.
package mdu_pkg;

  localparam logic [1:0] MDU_OP_NONE     = 2'b00;
  localparam logic [1:0] MDU_OP_UNSIGNED = 2'b01;
  localparam logic [1:0] MDU_OP_SIGNED   = 2'b10;

  // Cycles `done` stays low after an accept (32 CALC + 1 SIGN).
  localparam int unsigned DIV_LATENCY = 33;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StSign = 2'b10
  } div_state_t;

endpackage

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider (DIV / DIVU), one quotient bit per cycle.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset
//   div_op   - 2'b10 signed, 2'b01 unsigned, anything else no request
//   dividend - numerator, sampled on accept only
//   divisor  - denominator, sampled on accept only
//   result   - {remainder, quotient}, registered, updated on completion only
//   done     - registered; high when idle with a valid result, low while busy
module div_radix2
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         div_op,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] result,
  output logic               done
);

  localparam int unsigned CntW = $clog2(WIDTH);

  div_state_t       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] quo_q;      // shifts dividend bits out, quotient bits in
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dsr_q;      // |divisor|
  logic [WIDTH-1:0] raw_dvd_q;  // dividend as presented, for the divide-by-zero result
  logic             q_neg_q;
  logic             r_neg_q;
  logic             dz_q;

  logic             accept;
  logic             op_signed;
  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dsr;
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   trial;

  always_comb begin
    op_signed = (div_op == MDU_OP_SIGNED);
    accept    = (state_q == StIdle) && (op_signed || (div_op == MDU_OP_UNSIGNED));
    abs_dvd   = (op_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    abs_dsr   = (op_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    // Kept at WIDTH+1 bits so divisors >= 2^(WIDTH-1) still compare correctly.
    partial   = {rem_q, quo_q[WIDTH-1]};
    trial     = partial - {1'b0, dsr_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      raw_dvd_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dz_q      <= 1'b0;
      result    <= '0;
      done      <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            quo_q     <= abs_dvd;
            rem_q     <= '0;
            dsr_q     <= abs_dsr;
            raw_dvd_q <= dividend;
            q_neg_q   <= op_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_q   <= op_signed && dividend[WIDTH-1];
            dz_q      <= (divisor == '0);
            cnt_q     <= '0;
            done      <= 1'b0;
            state_q   <= StCalc;
          end
        end
        StCalc: begin
          // Non-negative trial: keep the difference and emit a 1.
          if (!trial[WIDTH]) begin
            rem_q <= trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= partial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q <= StSign;
          end
        end
        StSign: begin
          if (dz_q) begin
            result <= {raw_dvd_q, {WIDTH{1'b1}}};
          end else begin
            // Wrap-around negation yields 0x8000_0000 for the signed overflow case.
            result <= {(r_neg_q ? -rem_q : rem_q), (q_neg_q ? -quo_q : quo_q)};
          end
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          done    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// Scoreboard bench for div_radix2: the driver pushes expected results with
// their accept cycle; a monitor checks every done edge and result stability.
module tb_div_radix2;
  import mdu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   div_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [2*W-1:0] result;
  logic         done;

  div_radix2 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .div_op   (div_op),
    .dividend (dividend),
    .divisor  (divisor),
    .result   (result),
    .done     (done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] res;
    int unsigned    t;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int unsigned last_issue = 0;
  bit          skip_rise = 1'b0;
  bit          mon_en = 1'b0;
  bit          junk_mode = 1'b0;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer division; 64-bit signed arithmetic makes the
  // 0x8000_0000 / -1 case wrap to 0x8000_0000 in the low word naturally.
  function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sd, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (op == MDU_OP_SIGNED) begin
      sa = longint'($signed(a));
      sd = longint'($signed(b));
      q  = sa / sd;
      r  = sa % sd;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (done !== 1'b1) begin
      if (junk_mode) begin
        div_op   = 2'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
      end
      @(negedge clk);
      n++;
      if (n > 100) begin
        bad++;
        total++;
        $display("FAIL idle_timeout: done stuck low at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
      end
    end
    div_op = MDU_OP_NONE;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp_res, input bit junk);
    wait_idle();
    div_op   = op;
    dividend = a;
    divisor  = b;
    sb.push_back('{exp_res, cyc});
    last_issue = cyc;
    junk_mode  = junk;
    @(negedge clk);
    div_op = MDU_OP_NONE;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      div_op   = ($urandom_range(0, 1) != 0) ? 2'b11 : MDU_OP_NONE;
      dividend = $urandom;
      divisor  = $urandom;
      @(negedge clk);
    end
    div_op = MDU_OP_NONE;
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor
  initial begin
    logic           prev_done;
    logic [2*W-1:0] prev_res;
    exp_t           e;
    wait (mon_en);
    prev_done = done;
    prev_res  = result;
    forever begin
      @(negedge clk);
      if (done && !prev_done) begin
        if (skip_rise) begin
          skip_rise = 1'b0;
        end else if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done: got rise at cycle %0d want none", cyc);
        end else begin
          e = sb.pop_front();
          check("latency", 64'(cyc), 64'(e.t + DIV_LATENCY + 1));
          check("result", result, e.res);
        end
      end else if (!done && prev_done) begin
        check("accept_fall", 64'(cyc), 64'(last_issue + 1));
      end else if (done && prev_done) begin
        check("hold", result, prev_res);
      end
      prev_done = done;
      prev_res  = result;
    end
  end

  // Driver
  initial begin
    logic [1:0]   op;
    logic [W-1:0] a, b;
    int           n;
    rst      = 1'b1;
    div_op   = MDU_OP_NONE;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("reset_done", 64'(done), 64'd1);
    check("reset_result", result, 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    idle_cycles(2);

    issue(MDU_OP_UNSIGNED, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0);
    issue(MDU_OP_SIGNED, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    issue(MDU_OP_SIGNED, 32'h7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0);
    issue(MDU_OP_SIGNED, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
    issue(MDU_OP_UNSIGNED, 32'hFFFF_FFFF, 32'h1, 64'h0000_0000_FFFF_FFFF, 1'b0);
    issue(MDU_OP_UNSIGNED, 32'h5, 32'h0, 64'h0000_0005_FFFF_FFFF, 1'b0);
    issue(MDU_OP_SIGNED, 32'hFFFF_FFFB, 32'h0, 64'hFFFF_FFFB_FFFF_FFFF, 1'b0);
    issue(MDU_OP_UNSIGNED, 32'hFFFF_FFFF, 32'h8000_0001, 64'h7FFF_FFFE_0000_0001, 1'b0);
    // Junk on the inputs while busy, then a back-to-back request.
    issue(MDU_OP_UNSIGNED, 32'd1000, 32'd33, 64'h0000_000A_0000_001E, 1'b1);
    issue(MDU_OP_SIGNED, 32'hFFFF_FF9C, 32'd10, 64'h0000_0000_FFFF_FFF6, 1'b1);

    // Reset at T+10 discards the in-flight divide.
    issue(MDU_OP_SIGNED, 32'hFFFF_FF00, 32'd5, 64'h0, 1'b0);
    repeat (9) @(negedge clk);
    rst       = 1'b1;
    skip_rise = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    check("rst_done", 64'(done), 64'd1);
    check("rst_result", result, 64'd0);
    check("rst_cycle", 64'(cyc), 64'(last_issue + 11));
    rst = 1'b0;
    issue(MDU_OP_UNSIGNED, 32'd9, 32'd3, 64'h0000_0000_0000_0003, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      op = ($urandom_range(0, 1) != 0) ? MDU_OP_SIGNED : MDU_OP_UNSIGNED;
      a  = rand_operand();
      b  = rand_operand();
      issue(op, a, b, model(op, a, b), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        idle_cycles($urandom_range(1, 3));
      end
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
